// File: rtl/usb_fifo_rd.sv
// Slave-FIFO read master: polls the chip buffer flag, runs one fixed-length read
// burst and streams each returned word downstream with usb_rd_state as the qualifier.
module usb_fifo_rd #(
  parameter int         BURST_LEN   = 256,
  parameter logic [1:0] SOCKET_ADDR = 2'b00,
  parameter int         FLAG_WAIT   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flaga,
  input  logic [31:0] fdata,
  output logic        slcs_n,
  output logic        sloe_n,
  output logic        slrd_n,
  output logic [1:0]  fifoadr,
  output logic [31:0] data_out,
  output logic [3:0]  usb_rd_state,
  output logic        burst_done,
  output logic [15:0] burst_cnt
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_FLAG = 4'd1,
    CS_SETUP  = 4'd2,
    OE        = 4'd3,
    PRIME1    = 4'd4,
    PRIME2    = 4'd5,
    READ      = 4'd6,
    TURN      = 4'd7
  } state_t;

  localparam logic [10:0] WORD_LAST = 11'(BURST_LEN - 1);
  localparam logic [10:0] RD_STOP   = 11'(BURST_LEN - 2);
  localparam logic [3:0]  TURN_LAST = 4'(FLAG_WAIT - 1);

  state_t      state, state_nx;
  logic        flaga_r;
  logic [31:0] fdata_r;
  logic [10:0] word_cnt, word_nx;
  logic [3:0]  turn_cnt;

  // Downstream handshake: there is no ready; a word is valid on data_out exactly
  // in the cycles where usb_rd_state == READ (6), and each such cycle carries a new word.
  assign usb_rd_state = state;

  // Index of the READ cycle that follows this one (0 when READ is being entered).
  assign word_nx = (state == READ) ? word_cnt + 11'd1 : 11'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (en) state_nx = WAIT_FLAG;
      WAIT_FLAG: if (!en) state_nx = IDLE;
                 else if (flaga_r) state_nx = CS_SETUP;
      CS_SETUP:  state_nx = OE;
      OE:        state_nx = PRIME1;
      PRIME1:    state_nx = PRIME2;
      PRIME2:    state_nx = READ;
      READ:      if (word_cnt == WORD_LAST) state_nx = TURN;
      TURN:      if (turn_cnt == TURN_LAST) state_nx = en ? WAIT_FLAG : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flaga_r  <= 1'b0;
      fdata_r  <= '0;
      word_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      flaga_r  <= flaga;
      fdata_r  <= fdata;
      word_cnt <= (state_nx == READ) ? word_nx : 11'd0;
      turn_cnt <= (state == TURN && state_nx == TURN) ? turn_cnt + 4'd1 : 4'd0;
    end
  end

  // Strobes are registered from the next state so they line up with usb_rd_state.
  // The two PRIME strobes plus BURST_LEN-2 READ strobes give BURST_LEN reads in all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slcs_n     <= 1'b1;
      sloe_n     <= 1'b1;
      slrd_n     <= 1'b1;
      fifoadr    <= SOCKET_ADDR;
      data_out   <= '0;
      burst_done <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      slcs_n     <= (state_nx == IDLE) || (state_nx == TURN);
      sloe_n     <= !((state_nx == OE) || (state_nx == PRIME1) ||
                      (state_nx == PRIME2) || (state_nx == READ));
      slrd_n     <= !((state_nx == PRIME1) || (state_nx == PRIME2) ||
                      ((state_nx == READ) && (word_nx < RD_STOP)));
      fifoadr    <= SOCKET_ADDR;
      burst_done <= (state == READ) && (state_nx == TURN);
      if (state_nx == READ) data_out <= fdata_r;
      if ((state == READ) && (state_nx == TURN)) burst_cnt <= burst_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_usb_fifo_rd.sv
// Directed bench for usb_fifo_rd: a chip model feeds an incrementing pattern and
// a scoreboard queue holds each word handed out until it shows up on data_out.
module tb_usb_fifo_rd;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        flaga = 1'b0;
  logic [31:0] fdata;
  logic        slcs_n, sloe_n, slrd_n, burst_done;
  logic [1:0]  fifoadr;
  logic [31:0] data_out;
  logic [3:0]  usb_rd_state;
  logic [15:0] burst_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd_ptr;
  int          words, lows, dones, cyc, run_len;
  bit          in_run;
  int          run_starts[$];
  int          run_lens[$];

  usb_fifo_rd #(.BURST_LEN(256), .SOCKET_ADDR(2'b00), .FLAG_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flaga(flaga), .fdata(fdata),
    .slcs_n(slcs_n), .sloe_n(sloe_n), .slrd_n(slrd_n), .fifoadr(fifoadr),
    .data_out(data_out), .usb_rd_state(usb_rd_state),
    .burst_done(burst_done), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Chip model: the word at the read pointer is on the bus while slrd_n is low.
  assign fdata = 32'h1000 + rd_ptr;
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      exp_q.delete();
    end else if (!slrd_n) begin
      exp_q.push_back(fdata);
      rd_ptr <= rd_ptr + 32'd1;
    end
  end

  // Output side: every state-6 cycle pops one expected word.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      words = 0; lows = 0; dones = 0; in_run = 0; run_len = 0;
      run_starts.delete();
      run_lens.delete();
    end else begin
      if (usb_rd_state == 4'd6) begin
        if (!in_run) begin
          run_starts.push_back(cyc);
          run_len = 0;
          in_run  = 1;
        end
        run_len++;
        words++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $error("FAIL data_out: state 6 with empty scoreboard, observed %h", data_out);
        end else begin
          check("data_out", data_out, exp_q.pop_front());
        end
      end else if (in_run) begin
        run_lens.push_back(run_len);
        in_run = 0;
      end
      if (!slrd_n) lows++;
      if (burst_done) dones++;
    end
  end

  initial begin
    #3000000;
    $error("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int max);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (burst_done !== 1'b1 && i < max);
    check(tag, 32'(burst_done), 32'd1);
  endtask

  task automatic wait_words(input string tag, input int n, input int max);
    int i = 0;
    while (words < n && i < max) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(words >= n), 32'd1);
  endtask

  task automatic check_idle_strobes(input string tag);
    check({tag, "_slcs_n"}, 32'(slcs_n), 32'd1);
    check({tag, "_sloe_n"}, 32'(sloe_n), 32'd1);
    check({tag, "_slrd_n"}, 32'(slrd_n), 32'd1);
  endtask

  task automatic do_reset(input logic en_v, input logic flag_v);
    @(negedge clk);
    rst_n = 1'b0;
    en    = en_v;
    flaga = flag_v;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int cs_low;

    // Reset held 3 cycles with en and flaga high
    en = 1'b1;
    flaga = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_strobes("rst");
      check("rst_state", 32'(usb_rd_state), 32'd0);
      check("rst_burst_cnt", 32'(burst_cnt), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_burst_done", 32'(burst_done), 32'd0);
      check("rst_fifoadr", 32'(fifoadr), 32'd0);
    end

    // Single burst from a one-cycle flag pulse, flag low during the burst
    flaga = 1'b0;
    rst_n = 1'b1;
    tick(1);
    check("wait_state", 32'(usb_rd_state), 32'd1);
    check("wait_slcs_n", 32'(slcs_n), 32'd0);
    check("wait_sloe_n", 32'(sloe_n), 32'd1);
    tick(2);
    check("wait_hold", 32'(usb_rd_state), 32'd1);
    flaga = 1'b1;
    tick(1);
    flaga = 1'b0;
    check("t1_state", 32'(usb_rd_state), 32'd1);
    tick(1);
    check("t2_state", 32'(usb_rd_state), 32'd2);
    check("t2_sloe_n", 32'(sloe_n), 32'd1);
    tick(1);
    check("t3_state", 32'(usb_rd_state), 32'd3);
    check("t3_sloe_n", 32'(sloe_n), 32'd0);
    check("t3_slrd_n", 32'(slrd_n), 32'd1);
    tick(1);
    check("t4_state", 32'(usb_rd_state), 32'd4);
    check("t4_slrd_n", 32'(slrd_n), 32'd0);
    tick(1);
    check("t5_state", 32'(usb_rd_state), 32'd5);
    tick(1);
    check("t6_state", 32'(usb_rd_state), 32'd6);
    check("t6_first_word", data_out, 32'h1000);
    wait_done("single_done", 300);
    check("single_turn_state", 32'(usb_rd_state), 32'd7);
    check("single_burst_cnt", 32'(burst_cnt), 32'd1);
    check_idle_strobes("turn");
    check("single_last_word", data_out, 32'h10FF);
    tick(1);
    check("single_done_pulse", 32'(burst_done), 32'd0);
    check("turn_data_hold", data_out, 32'h10FF);
    tick(30);
    check("glitch_sits_wait", 32'(usb_rd_state), 32'd1);
    check("single_words", 32'(words), 32'd256);
    check("single_lows", 32'(lows), 32'd256);
    check("single_dones", 32'(dones), 32'd1);
    check("single_runs", 32'(run_lens.size()), 32'd1);
    if (run_lens.size() == 1) check("single_run_len", 32'(run_lens[0]), 32'd256);
    check("single_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back bursts with the flag held high
    do_reset(1'b1, 1'b1);
    wait_done("b2b_done1", 300);
    wait_done("b2b_done2", 300);
    wait_done("b2b_done3", 300);
    flaga = 1'b0;
    tick(20);
    check("b2b_burst_cnt", 32'(burst_cnt), 32'd3);
    check("b2b_words", 32'(words), 32'd768);
    check("b2b_lows", 32'(lows), 32'd768);
    check("b2b_runs", 32'(run_starts.size()), 32'd3);
    if (run_starts.size() == 3) begin
      check("b2b_period1", 32'(run_starts[1] - run_starts[0]), 32'd264);
      check("b2b_period2", 32'(run_starts[2] - run_starts[1]), 32'd264);
    end
    foreach (run_lens[i]) check("b2b_run_len", 32'(run_lens[i]), 32'd256);
    check("b2b_last_word", data_out, 32'h12FF);
    check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    // en dropped mid-READ near word 100
    do_reset(1'b1, 1'b0);
    tick(2);
    flaga = 1'b1;
    tick(1);
    flaga = 1'b0;
    wait_words("en_reach_100", 100, 400);
    en = 1'b0;
    wait_done("en_done", 300);
    check("en_turn0", 32'(usb_rd_state), 32'd7);
    tick(1);
    check("en_turn1", 32'(usb_rd_state), 32'd7);
    tick(1);
    check("en_turn2", 32'(usb_rd_state), 32'd7);
    tick(1);
    check("en_to_idle", 32'(usb_rd_state), 32'd0);
    cs_low = 0;
    repeat (20) begin
      tick(1);
      if (!slcs_n) cs_low++;
    end
    check("en_no_cs", 32'(cs_low), 32'd0);
    check("en_words", 32'(words), 32'd256);
    check("en_lows", 32'(lows), 32'd256);
    check("en_burst_cnt", 32'(burst_cnt), 32'd1);

    // Reset mid-READ near word 50
    do_reset(1'b1, 1'b0);
    tick(2);
    flaga = 1'b1;
    tick(1);
    flaga = 1'b0;
    wait_words("rstmid_reach_50", 50, 400);
    check("rstmid_no_done_yet", 32'(dones), 32'd0);
    rst_n = 1'b0;
    en = 1'b0;
    tick(1);
    check_idle_strobes("rstmid");
    check("rstmid_state", 32'(usb_rd_state), 32'd0);
    check("rstmid_burst_done", 32'(burst_done), 32'd0);
    check("rstmid_burst_cnt", 32'(burst_cnt), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("rstmid_idle", 32'(usb_rd_state), 32'd0);
    check("rstmid_dones", 32'(dones), 32'd0);
    check("rstmid_cnt_after", 32'(burst_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
